// File: rtl/loctag_adc_pkg.sv
// Shared types and frame constants for the LT5534 detector ADC sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package loctag_adc_pkg;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    QUIET = 2'd3
  } adc_state_e;

  // Serial frame layout: lead zeros followed by the conversion result, MSB first
  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_LEAD_ZEROS = 4;
  localparam int ADC_DATA_W     = ADC_FRAME_BITS - ADC_LEAD_ZEROS;

endpackage

// File: rtl/adc_trig_sync.sv
// Synchronises the raw trigger pin and emits a one-cycle pulse on its rising edge.
// Latency: pulse is high the 2nd clk cycle after trig_in rises (two synchroniser flops).
// Backpressure: none; every synchronised rising edge produces exactly one pulse.
module adc_trig_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic trig_in,
  output logic trig_pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next-state: plain shift through the synchroniser and the edge-history flop
  always_comb begin
    meta_d = trig_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchroniser chain, cleared on reset so a high pin at release looks like an edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign trig_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/adc_sample_ctrl.sv
// Drives cs_n/sclk of the detector ADC, shifts in one frame per conversion, offers the result on valid/ready.
// Latency: frame start to cs_n high (sample_valid) = 1 + 2*CLK_DIV*FRAME_BITS cycles; trig pin to start ~3 cycles.
// Backpressure: sample held until sample_ready; a frame finishing while still pending is dropped and sets overrun.
// Optional ADC_THRESHOLD_EN adds thresh/over_thresh: one-cycle flag when a loaded sample is >= thresh.
module adc_sample_ctrl
  import loctag_adc_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int FRAME_BITS = ADC_FRAME_BITS,
  parameter int DATA_W     = ADC_DATA_W,
  parameter int QUIET_CYC  = 4,
  parameter int PERIOD_W   = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                trig_mode,
  input  logic [PERIOD_W-1:0] sample_period,
  input  logic                trig_in,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  input  logic                adc_so,
  output logic [DATA_W-1:0]   sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                busy,
  output logic                overrun,
  input  logic                overrun_clr,
`ifdef ADC_THRESHOLD_EN
  input  logic [DATA_W-1:0]   thresh,
  output logic                over_thresh,
`endif
  output logic                trig_miss
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam int Q_W   = $clog2(QUIET_CYC + 1);

  logic trig_pulse;

  adc_trig_sync u_trig_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .trig_in    (trig_in),
    .trig_pulse (trig_pulse)
  );

  adc_state_e          state_q,   state_d;
  logic                cs_n_q,    cs_n_d;
  logic                sclk_q,    sclk_d;
  logic [DIV_W-1:0]    div_q,     div_d;
  logic [BIT_W-1:0]    bit_q,     bit_d;
  logic [Q_W-1:0]      quiet_q,   quiet_d;
  logic [DATA_W-1:0]   shift_q,   shift_d;
  logic [PERIOD_W-1:0] per_q,     per_d;
  logic                mode_q,    mode_d;
  logic [DATA_W-1:0]   data_q,    data_d;
  logic                valid_q,   valid_d;
  logic                busy_q,    busy_d;
  logic                overrun_q, overrun_d;
  logic                miss_q,    miss_d;
`ifdef ADC_THRESHOLD_EN
  logic                over_q,    over_d;
`endif

  logic                eff_mode;
  logic [PERIOD_W-1:0] period_last;
  logic                per_due;
  logic                start;
  logic                frame_done;
  logic                load;

  // Next-state for sequencer, period counter and output handshake
  always_comb begin
    state_d   = state_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    div_d     = div_q;
    bit_d     = bit_q;
    quiet_d   = quiet_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    frame_done = 1'b0;

    // Mode is only re-sampled while idle so a frame never changes personality midway
    eff_mode = (state_q == IDLE) ? trig_mode : mode_q;
    mode_d   = eff_mode;

    // A period of 0 behaves like 1: start as soon as the sequencer is idle
    period_last = (sample_period == '0) ? '0 : sample_period - PERIOD_W'(1);
    per_due     = (per_q >= period_last);
    // Saturate so a long idle stretch cannot wrap and delay the next start
    per_d       = (per_q == '1) ? per_q : per_q + PERIOD_W'(1);

    start = (state_q == IDLE) && enable && (eff_mode ? trig_pulse : per_due);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
          per_d   = '0;
        end
      end
      SETUP: begin
        state_d = SHIFT;
        sclk_d  = 1'b0;
        div_d   = '0;
        bit_d   = '0;
      end
      SHIFT: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!sclk_q) begin
            // Rising sclk: the ADC has held this bit for a full low half-period
            sclk_d  = 1'b1;
            shift_d = {shift_q[DATA_W-2:0], adc_so};
          end else if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
            // Last high half-period complete: leave sclk idling high and release cs_n
            cs_n_d     = 1'b1;
            state_d    = QUIET;
            quiet_d    = '0;
            frame_done = 1'b1;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + BIT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      QUIET: begin
        if (quiet_q == Q_W'(QUIET_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          quiet_d = quiet_q + Q_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
    // Edges arriving while a frame or quiet time is running are reported, not queued
    miss_d = trig_pulse && eff_mode && (state_q != IDLE);

    // Shift register only keeps the low DATA_W bits, so the lead zeros fall off the top
    load = frame_done && (!valid_q || sample_ready);
    if (load) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end

    if (overrun_clr) begin
      overrun_d = 1'b0;
    end else if (frame_done && !load) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

`ifdef ADC_THRESHOLD_EN
    over_d = load && (shift_q >= thresh);
`endif
  end

  // Sequencer state and all registered outputs; reset aborts any frame in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      div_q     <= '0;
      bit_q     <= '0;
      quiet_q   <= '0;
      shift_q   <= '0;
      per_q     <= '0;
      mode_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      miss_q    <= 1'b0;
`ifdef ADC_THRESHOLD_EN
      over_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      quiet_q   <= quiet_d;
      shift_q   <= shift_d;
      per_q     <= per_d;
      mode_q    <= mode_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      miss_q    <= miss_d;
`ifdef ADC_THRESHOLD_EN
      over_q    <= over_d;
`endif
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign trig_miss    = miss_q;
`ifdef ADC_THRESHOLD_EN
  assign over_thresh  = over_q;
`endif

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed bench for adc_sample_ctrl with a behavioural serial ADC and cs_n/trig_miss monitors.
// Latency: n/a.
// Backpressure: sample_ready driven by the stimulus sequence.
module tb_adc_sample_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        trig_mode;
  logic [15:0] sample_period;
  logic        trig_in;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_so;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        busy;
  logic        overrun;
  logic        overrun_clr;
  logic        trig_miss;
`ifdef ADC_THRESHOLD_EN
  logic [11:0] thresh;
  logic        over_thresh;
`endif

  always #5 clk = ~clk;

  adc_sample_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .trig_mode     (trig_mode),
    .sample_period (sample_period),
    .trig_in       (trig_in),
    .adc_cs_n      (adc_cs_n),
    .adc_sclk      (adc_sclk),
    .adc_so        (adc_so),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .busy          (busy),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr),
`ifdef ADC_THRESHOLD_EN
    .thresh        (thresh),
    .over_thresh   (over_thresh),
`endif
    .trig_miss     (trig_miss)
  );

  // ADC model: the word to send, MSB first, advancing one bit per sclk rising edge
  logic [15:0] adc_word = 16'h0000;
  logic [4:0]  rise_n = 5'd0;
  assign adc_so = (rise_n < 5'd16) ? adc_word[4'd15 - rise_n[3:0]] : 1'b0;

  // Monitors, all sampled on the falling clk edge
  int   cyc      = 0;
  int   miss_cnt = 0;
  int   fall_q[$];
  logic cs_prev   = 1'b1;
  logic sclk_prev = 1'b1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (trig_miss === 1'b1) miss_cnt = miss_cnt + 1;
    if (cs_prev === 1'b1 && adc_cs_n === 1'b0) begin
      fall_q.push_back(cyc);
      rise_n = 5'd0;
    end else if (sclk_prev === 1'b0 && adc_sclk === 1'b1 && adc_cs_n === 1'b0 && rise_n < 5'd16) begin
      rise_n = rise_n + 5'd1;
    end
    cs_prev   = adc_cs_n;
    sclk_prev = adc_sclk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) until cs_n reaches lvl; n = negedges waited
  task automatic wait_cs(input logic lvl, input int budget, output int n);
    n = 0;
    while (adc_cs_n !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_cs", {31'd0, adc_cs_n}, {31'd0, lvl});
  endtask

  task automatic wait_falls(input int target, input int budget);
    int n;
    n = 0;
    while (fall_q.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("falls_seen", fall_q.size(), target);
  endtask

  // One triggered frame: clean edge on trig_in, returns cycles to cs_n low and cs_n-low duration
  task automatic run_trig_frame(input logic [15:0] w, output int n_lo, output int n_dur);
    trig_in = 1'b0;
    repeat (4) @(negedge clk);
    adc_word = w;
    trig_in  = 1'b1;
    wait_cs(1'b0, 20, n_lo);
    wait_cs(1'b1, 200, n_dur);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_lo, n_dur, base, miss0, d;
    reset_n       = 1'b0;
    enable        = 1'b1;
    trig_mode     = 1'b1;
    sample_period = 16'd200;
    trig_in       = 1'b0;
    sample_ready  = 1'b0;
    overrun_clr   = 1'b0;
`ifdef ADC_THRESHOLD_EN
    thresh        = 12'h800;
`endif
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cs_n",    {31'd0, adc_cs_n},     32'd1);
    chk("rst_sclk",    {31'd0, adc_sclk},     32'd1);
    chk("rst_data",    {20'd0, sample_data},  32'd0);
    chk("rst_valid",   {31'd0, sample_valid}, 32'd0);
    chk("rst_busy",    {31'd0, busy},         32'd0);
    chk("rst_overrun", {31'd0, overrun},      32'd0);
    chk("rst_miss",    {31'd0, trig_miss},    32'd0);

    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("trig_idle_no_start", fall_q.size(), 0);

    // Triggered frame: 0x0A5C -> 0xA5C, 65 cycles of cs_n low, 16 sclk rising edges
    run_trig_frame(16'h0A5C, n_lo, n_dur);
    chk("trig_to_cs_lat", n_lo,  3);
    chk("cs_low_cycles",  n_dur, 65);
    chk("t1_valid",    {31'd0, sample_valid}, 32'd1);
    chk("t1_data",     {20'd0, sample_data},  32'h0A5C);
    chk("t1_sclk_rise", {27'd0, rise_n},      32'd16);
    chk("t1_sclk_idle", {31'd0, adc_sclk},    32'd1);
    repeat (3) @(negedge clk);
    chk("quiet_busy",  {31'd0, busy},         32'd1);
    @(negedge clk);
    chk("idle_busy",   {31'd0, busy},         32'd0);
    chk("t1_no_miss",  miss_cnt, 0);
    repeat (5) @(negedge clk);
    chk("t1_valid_held", {31'd0, sample_valid}, 32'd1);
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    chk("t1_valid_drop", {31'd0, sample_valid}, 32'd0);

    // Trig edge during SHIFT: one trig_miss pulse, no extra frame
    base     = fall_q.size();
    miss0    = miss_cnt;
    trig_in  = 1'b0;
    repeat (4) @(negedge clk);
    adc_word = 16'h0123;
    trig_in  = 1'b1;
    wait_cs(1'b0, 20, n_lo);
    repeat (10) @(negedge clk);
    trig_in = 1'b0;
    repeat (3) @(negedge clk);
    trig_in = 1'b1;
    wait_cs(1'b1, 200, n_dur);
    chk("t2_data", {20'd0, sample_data}, 32'h0123);
    repeat (20) @(negedge clk);
    chk("t2_miss_pulse", miss_cnt - miss0, 1);
    chk("t2_one_frame",  fall_q.size() - base, 1);

    // Second frame with ready low: old sample held, overrun set, then cleared
    run_trig_frame(16'h0FFF, n_lo, n_dur);
    chk("t3_data_held", {20'd0, sample_data},  32'h0123);
    chk("t3_valid",     {31'd0, sample_valid}, 32'd1);
    chk("t3_overrun",   {31'd0, overrun},      32'd1);
    repeat (5) @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("t3_overrun_clr", {31'd0, overrun}, 32'd0);
    sample_ready = 1'b1;
    @(negedge clk);
    chk("t3_valid_drop", {31'd0, sample_valid}, 32'd0);

    // Continuous mode, period 200; trig edges ignored
    repeat (10) @(negedge clk);
    miss0     = miss_cnt;
    adc_word  = 16'h0456;
    trig_mode = 1'b0;
    trig_in   = 1'b0;
    base      = fall_q.size();
    repeat (100) @(negedge clk);
    trig_in = 1'b1;
    wait_falls(base + 3, 800);
    d = fall_q[base+1] - fall_q[base];
    chk("period200_a", d, 200);
    d = fall_q[base+2] - fall_q[base+1];
    chk("period200_b", d, 200);
    chk("cont_no_miss", miss_cnt - miss0, 0);
    wait_cs(1'b1, 200, n_dur);
    chk("cont_valid",   {31'd0, sample_valid}, 32'd1);
    chk("cont_data",    {20'd0, sample_data},  32'h0456);
    chk("cont_overrun", {31'd0, overrun},      32'd0);

    // Period 0 -> back-to-back: 1 setup + 64 shift + 4 quiet + 1 idle
    sample_period = 16'd0;
    base = fall_q.size();
    wait_falls(base + 3, 800);
    d = fall_q[base+2] - fall_q[base+1];
    chk("period0", d, 70);

    // enable dropped mid-frame: frame completes and delivers, then no more starts
    wait_cs(1'b1, 200, n_dur);
    adc_word = 16'h0BCD;
    wait_cs(1'b0, 100, n_lo);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_cs(1'b1, 200, n_dur);
    chk("dis_valid", {31'd0, sample_valid}, 32'd1);
    chk("dis_data",  {20'd0, sample_data},  32'h0BCD);
    base = fall_q.size();
    repeat (300) @(negedge clk);
    chk("dis_no_start", fall_q.size() - base, 0);
    chk("dis_busy",     {31'd0, busy}, 32'd0);

    // Reset mid-SHIFT aborts immediately
    sample_period = 16'd200;
    enable = 1'b1;
    wait_cs(1'b0, 300, n_lo);
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    trig_in = 1'b0;
    #1;
    chk("abort_cs_n",  {31'd0, adc_cs_n},     32'd1);
    chk("abort_sclk",  {31'd0, adc_sclk},     32'd1);
    chk("abort_valid", {31'd0, sample_valid}, 32'd0);
    chk("abort_busy",  {31'd0, busy},         32'd0);
    @(negedge clk);
    trig_mode = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    run_trig_frame(16'h0789, n_lo, n_dur);
    chk("post_rst_dur",  n_dur, 65);
    chk("post_rst_data", {20'd0, sample_data}, 32'h0789);
    chk("post_rst_rise", {27'd0, rise_n},      32'd16);

`ifdef ADC_THRESHOLD_EN
    // Threshold compare at the boundary
    repeat (10) @(negedge clk);
    run_trig_frame(16'h07FF, n_lo, n_dur);
    chk("thr_7ff_valid", {31'd0, sample_valid}, 32'd1);
    chk("thr_7ff",       {31'd0, over_thresh},  32'd0);
    repeat (10) @(negedge clk);
    run_trig_frame(16'h0800, n_lo, n_dur);
    chk("thr_800",       {31'd0, over_thresh},  32'd1);
    @(negedge clk);
    chk("thr_pulse_end", {31'd0, over_thresh},  32'd0);
`endif

    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
